lcd_panel_responder: RTL and testbench

- Behavioural/synthesizable model of the HD44780-style character panel at the far end of the 8-bit LCD bus (en, RS, RW, data).
- Accepts instruction and data writes and serves busy-flag and DDRAM reads.
- Holds a 2x16 character RAM, readable through a debug port.
- Used as the bus responder in LCD driver benches and as an on-chip loopback target on the DE0 board.

---
 rtl/lcd_panel_responder_if.sv | 12 +
 rtl/lcd_panel_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd_panel_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_panel_responder_if.sv
// 8-bit HD44780-style LCD bus between a driver (master) and the panel model (slave).
interface lcd_panel_responder_if;
  logic       en;
  logic       RS;
  logic       RW;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       dataOe;

  modport master (output en, RS, RW, dataIn, input dataOut, dataOe);
  modport slave  (input en, RS, RW, dataIn, output dataOut, dataOe);
endinterface

// File: rtl/lcd_panel_responder.sv
// HD44780-style character panel responder: 2x16 DDRAM, busy timing, status/data reads.
// BUSY_LONG must be >= 32 so the clear loop never overlaps an accepted bus write.
module lcd_panel_responder #(
  parameter int BUSY_SHORT = 4,
  parameter int BUSY_LONG  = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_panel_responder_if.slave bus,
  output logic                 busy,
  output logic [6:0]           addrCounter,
  output logic                 displayOn,
  output logic                 cursorOn,
  output logic                 blinkOn,
  input  logic [4:0]           rdIdx,
  output logic [7:0]           rdChar,
  output logic                 cmdErr
);

  localparam int CW = $clog2(BUSY_LONG + 1);
  localparam logic [CW-1:0] CNT_SHORT = CW'(BUSY_SHORT);
  localparam logic [CW-1:0] CNT_LONG  = CW'(BUSY_LONG);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t          state, state_nxt;
  logic [4:0]      clr_idx;
  logic [CW-1:0]   busy_cnt;
  logic            bus_busy;

  logic            en_q, rs_q, rw_q;
  logic [7:0]      d_q;
  logic            en_fall;

  logic            inc_mode;
  logic            shift_unused;
  logic [7:0]      mem [32];
  logic [4:0]      ac_idx;

  logic [6:0]      ac_nxt;
  logic            inc_nxt, shift_nxt;
  logic            disp_nxt, curs_nxt, blink_nxt;
  logic            load_short, load_long, err_nxt;
  logic            bus_we, clear_start;
  logic            mem_we;
  logic [4:0]      mem_wa;
  logic [7:0]      mem_wd;

  // Address counter step with the 0x0F<->0x40 and 0x4F<->0x00 line wraps.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h0F)      ac_step = 7'h40;
      else if (a == 7'h4F) ac_step = 7'h00;
      else                 ac_step = a + 7'd1;
    end else begin
      if (a == 7'h00)      ac_step = 7'h4F;
      else if (a == 7'h40) ac_step = 7'h0F;
      else                 ac_step = a - 7'd1;
    end
  endfunction

  assign busy     = (busy_cnt != '0);
  // A counter at 1 expires on this edge, so a transaction ending now sees the panel free.
  assign bus_busy = (busy_cnt > CNT_ONE);
  assign en_fall  = en_q & ~bus.en;
  assign ac_idx   = {addrCounter[6], addrCounter[3:0]};
  assign bus.dataOe = en_q & rw_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    ac_nxt      = addrCounter;
    inc_nxt     = inc_mode;
    shift_nxt   = shift_unused;
    disp_nxt    = displayOn;
    curs_nxt    = cursorOn;
    blink_nxt   = blinkOn;
    load_short  = 1'b0;
    load_long   = 1'b0;
    err_nxt     = 1'b0;
    bus_we      = 1'b0;
    clear_start = 1'b0;
    if (en_fall) begin
      if (!rw_q) begin
        if (bus_busy) begin
          err_nxt = 1'b1;
        end else if (rs_q) begin
          bus_we     = 1'b1;
          ac_nxt     = ac_step(addrCounter, inc_mode);
          load_short = 1'b1;
        end else if (d_q[7]) begin
          if (d_q[5:4] == 2'b00) begin
            ac_nxt     = d_q[6:0];
            load_short = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (d_q[6] || d_q[5]) begin
          load_short = 1'b1;
        end else if (d_q[4]) begin
          if (!d_q[3]) ac_nxt = ac_step(addrCounter, d_q[2]);
          load_short = 1'b1;
        end else if (d_q[3]) begin
          disp_nxt   = d_q[2];
          curs_nxt   = d_q[1];
          blink_nxt  = d_q[0];
          load_short = 1'b1;
        end else if (d_q[2]) begin
          inc_nxt    = d_q[1];
          shift_nxt  = d_q[0];
          load_short = 1'b1;
        end else if (d_q[1]) begin
          ac_nxt    = 7'h00;
          load_long = 1'b1;
        end else if (d_q[0]) begin
          ac_nxt      = 7'h00;
          inc_nxt     = 1'b1;
          clear_start = 1'b1;
          load_long   = 1'b1;
        end else begin
          load_short = 1'b1;
        end
      end else if (rs_q) begin
        if (bus_busy) err_nxt = 1'b1;
        else          ac_nxt  = ac_step(addrCounter, inc_mode);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_idx == 5'd31) state_nxt = ST_RUN;
      ST_RUN:   if (clear_start)      state_nxt = ST_CLEAR;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_idx;
    mem_wd = 8'h20;
    if (state == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (bus_we) begin
      mem_we = 1'b1;
      mem_wa = ac_idx;
      mem_wd = d_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= 5'd0;
    end else begin
      state   <= state_nxt;
      clr_idx <= (state == ST_CLEAR) ? clr_idx + 5'd1 : 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= CNT_LONG;
    end else if (load_long) begin
      busy_cnt <= CNT_LONG;
    end else if (load_short) begin
      busy_cnt <= CNT_SHORT;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
      rs_q <= 1'b0;
      rw_q <= 1'b0;
      d_q  <= 8'h00;
    end else begin
      en_q <= bus.en;
      if (bus.en) begin
        rs_q <= bus.RS;
        rw_q <= bus.RW;
        d_q  <= bus.dataIn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrCounter  <= 7'h00;
      inc_mode     <= 1'b1;
      shift_unused <= 1'b0;
      displayOn    <= 1'b0;
      cursorOn     <= 1'b0;
      blinkOn      <= 1'b0;
      cmdErr       <= 1'b0;
    end else begin
      addrCounter  <= ac_nxt;
      inc_mode     <= inc_nxt;
      shift_unused <= shift_nxt;
      displayOn    <= disp_nxt;
      cursorOn     <= curs_nxt;
      blinkOn      <= blink_nxt;
      cmdErr       <= err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dataOut <= 8'h00;
    end else if (bus.en && bus.RW) begin
      if (!bus.RS)      bus.dataOut <= {busy, addrCounter};
      else if (bus_busy) bus.dataOut <= 8'h00;
      else               bus.dataOut <= mem[ac_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdChar <= 8'h00;
    else     rdChar <= mem[rdIdx];
  end

  // NOTE: the RAM has no reset; the post-reset clear loop initialises it, keeping it a plain RAM array.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_lcd_panel_responder.sv
// Directed self-checking bench for lcd_panel_responder with hand-computed expectations.
module tb_lcd_panel_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [6:0] addrCounter;
  logic       displayOn, cursorOn, blinkOn;
  logic [4:0] rdIdx = 5'd0;
  logic [7:0] rdChar;
  logic       cmdErr;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_panel_responder_if bus ();

  lcd_panel_responder #(.BUSY_SHORT(4), .BUSY_LONG(40)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .addrCounter (addrCounter),
    .displayOn   (displayOn),
    .cursorOn    (cursorOn),
    .blinkOn     (blinkOn),
    .rdIdx       (rdIdx),
    .rdChar      (rdChar),
    .cmdErr      (cmdErr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(posedge clk); #1;
    bus.en = 1'b1; bus.RS = rs; bus.RW = 1'b0; bus.dataIn = d;
    @(posedge clk); #1;
    bus.en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] d);
    @(posedge clk); #1;
    bus.en = 1'b1; bus.RS = rs; bus.RW = 1'b1;
    @(posedge clk); #1;
    check("oe_during_read", bus.dataOe, 1'b1);
    bus.en = 1'b0;
    d = bus.dataOut;
    @(posedge clk); #1;
    check("oe_after_read", bus.dataOe, 1'b0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    count_busy(n);
    if (n >= 200) check("idle_timeout", n, 0);
  endtask

  task automatic peek(input logic [4:0] idx, output logic [7:0] v);
    rdIdx = idx;
    @(posedge clk); #1;
    v = rdChar;
  endtask

  initial begin
    int         n;
    logic [7:0] d;
    logic [7:0] v;

    bus.en = 1'b0; bus.RS = 1'b0; bus.RW = 1'b0; bus.dataIn = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b1);
    check("rst_ac", addrCounter, 7'h00);
    check("rst_disp", {displayOn, cursorOn, blinkOn}, 3'b000);
    check("rst_oe", bus.dataOe, 1'b0);
    check("rst_dout", bus.dataOut, 8'h00);
    check("rst_err", cmdErr, 1'b0);
    check("rst_rdchar", rdChar, 8'h00);
    rst = 1'b0;
    count_busy(n);
    check("init_busy_len", n, 40);
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      check("init_ram", v, 8'h20);
    end
    bus_read(1'b0, d);
    check("status_idle", d, 8'h00);

    // Display control then first character
    bus_write(1'b0, 8'h0F);
    count_busy(n);
    check("busy_len_instr", n, 4);
    check("disp_bits", {displayOn, cursorOn, blinkOn}, 3'b111);
    bus_write(1'b1, 8'h41);
    count_busy(n);
    check("busy_len_data", n, 4);
    check("ac_after_data", addrCounter, 7'h01);
    peek(5'd0, v);
    check("ram0", v, 8'h41);

    // Write while busy is rejected
    bus_write(1'b0, 8'h06);
    bus_write(1'b1, 8'h55);
    check("err_pulse", cmdErr, 1'b1);
    @(posedge clk); #1;
    check("err_single", cmdErr, 1'b0);
    check("ac_after_reject", addrCounter, 7'h01);
    wait_idle();
    peek(5'd1, v);
    check("ram1_unchanged", v, 8'h20);

    // Line wraps
    bus_write(1'b0, 8'h8F); wait_idle();
    check("ac_set_0f", addrCounter, 7'h0F);
    bus_write(1'b1, 8'h5A); wait_idle();
    check("ac_wrap_40", addrCounter, 7'h40);
    peek(5'd15, v);
    check("ram15", v, 8'h5A);
    bus_write(1'b0, 8'h04); wait_idle();
    bus_write(1'b0, 8'h80); wait_idle();
    bus_write(1'b1, 8'h33); wait_idle();
    check("ac_dec_wrap_4f", addrCounter, 7'h4F);
    peek(5'd0, v);
    check("ram0_dec", v, 8'h33);
    bus_write(1'b0, 8'h06); wait_idle();
    bus_write(1'b0, 8'h14); wait_idle();
    check("shift_right_wrap", addrCounter, 7'h00);
    bus_write(1'b0, 8'h10); wait_idle();
    check("shift_left_wrap", addrCounter, 7'h4F);

    // Read-back, busy reads and invalid address
    bus_write(1'b0, 8'h83); wait_idle();
    bus_write(1'b1, 8'h77); wait_idle();
    check("ac_after_77", addrCounter, 7'h04);
    peek(5'd3, v);
    check("ram3", v, 8'h77);
    bus_write(1'b0, 8'h83);
    bus_read(1'b1, d);
    check("busy_data_read", d, 8'h00);
    check("busy_read_err", cmdErr, 1'b1);
    check("busy_read_ac", addrCounter, 7'h03);
    wait_idle();
    bus_write(1'b0, 8'h83);
    bus_read(1'b0, d);
    check("status_busy", d, 8'h83);
    wait_idle();
    bus_read(1'b1, d);
    check("data_read", d, 8'h77);
    check("data_read_ac", addrCounter, 7'h04);
    check("data_read_noerr", cmdErr, 1'b0);
    bus_write(1'b0, 8'h95);
    check("bad_addr_err", cmdErr, 1'b1);
    check("bad_addr_ac", addrCounter, 7'h04);
    check("bad_addr_nobusy", busy, 1'b0);

    // Fill RAM, clear, reset mid-clear
    bus_write(1'b0, 8'h80); wait_idle();
    for (int i = 0; i < 32; i++) begin
      bus_write(1'b1, 8'(8'h30 + i));
      wait_idle();
    end
    check("fill_ac_wrap", addrCounter, 7'h00);
    peek(5'd20, v);
    check("fill_ram20", v, 8'h44);
    bus_write(1'b0, 8'h85); wait_idle();
    bus_write(1'b0, 8'h01);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midclr_busy", busy, 1'b1);
    check("midclr_ac", addrCounter, 7'h00);
    check("midclr_disp", {displayOn, cursorOn, blinkOn}, 3'b000);
    rst = 1'b0;
    bus_read(1'b0, d);
    check("status_after_rst", d, 8'h80);
    count_busy(n);
    check("rerst_busy_len", n + 3, 40);
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      check("rerst_ram", v, 8'h20);
    end
    check("rerst_ac", addrCounter, 7'h00);
    bus_read(1'b0, d);
    check("rerst_status", d, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
